// File: rtl/jtag_debug_cmd_sysclk_bridge_if.sv
// Command/status bundle between the virtual-JTAG sysclk bridge and its environment.
// parity_err exists only when JTAG_CMD_PARITY_EN is defined.
interface jtag_debug_cmd_sysclk_bridge_if #(
  parameter int IR_W = 2,
  parameter int SR_W = 38
);
  localparam int NCMD = 2 ** IR_W;

  logic [IR_W-1:0] ir_in;
  logic [SR_W-1:0] sr;
  logic            vs_uir;
  logic            vs_udr;
  logic            cmd_ack;
  logic [SR_W-1:0] jdo;
  logic [NCMD-1:0] take_action;
  logic [NCMD-1:0] take_no_action;
  logic            cmd_busy;
  logic [7:0]      overrun_cnt;
  logic            ack_timeout;
`ifdef JTAG_CMD_PARITY_EN
  logic            parity_err;
`endif

  modport master (
    output ir_in, sr, vs_uir, vs_udr, cmd_ack,
    input  jdo, take_action, take_no_action, cmd_busy, overrun_cnt, ack_timeout
`ifdef JTAG_CMD_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  ir_in, sr, vs_uir, vs_udr, cmd_ack,
    output jdo, take_action, take_no_action, cmd_busy, overrun_cnt, ack_timeout
`ifdef JTAG_CMD_PARITY_EN
    , output parity_err
`endif
  );
endinterface

// File: rtl/jtag_debug_cmd_sysclk_bridge.sv
// Resyncs vJTAG update strobes into clk, captures sr into jdo and issues one-hot command strobes SYNC_STAGES+3 cycles after udr rise.
// New commands are dropped (and counted) until cmd_ack or ACK_TO timeout; JTAG_CMD_PARITY_EN adds a parity gate with parity_err.
module jtag_debug_cmd_sysclk_bridge #(
  parameter int IR_W        = 2,
  parameter int SR_W        = 38,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TO      = 255
) (
  input logic                         clk,
  input logic                         reset_n,
  jtag_debug_cmd_sysclk_bridge_if.slave bus
);
  localparam int          NCMD     = 2 ** IR_W;
  localparam logic [15:0] ACK_TO_W = 16'(ACK_TO);

  typedef enum logic [1:0] {IDLE, CAPTURE, ISSUE, WAIT_ACK} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic [SYNC_STAGES-1:0] udr_sync;
  logic                   uir_last;
  logic                   udr_last;
  logic                   uir_rise;
  logic                   udr_rise;
  logic [SR_W-1:0]        jdo_q;
  logic [IR_W-1:0]        ir_q;
  logic [NCMD-1:0]        ta_q;
  logic [NCMD-1:0]        tna_q;
  logic [NCMD-1:0]        ir_onehot;
  logic                   busy_q;
  logic [7:0]             ovr_q;
  logic                   to_q;
  logic [15:0]            wait_cnt;
  logic                   ack_pend;
  logic                   ack_any;
  logic                   parity_ok;
  logic                   issue_fire;
  logic                   timeout_fire;
  logic                   wait_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync <= '0;
      udr_sync <= '0;
      uir_last <= 1'b0;
      udr_last <= 1'b0;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], bus.vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], bus.vs_udr};
      uir_last <= uir_sync[SYNC_STAGES-1];
      udr_last <= udr_sync[SYNC_STAGES-1];
    end
  end

  assign uir_rise  = uir_sync[SYNC_STAGES-1] & ~uir_last;
  assign udr_rise  = udr_sync[SYNC_STAGES-1] & ~udr_last;
  assign ack_any   = ack_pend | bus.cmd_ack;
  assign ir_onehot = NCMD'(1) << ir_q;

`ifdef JTAG_CMD_PARITY_EN
  // Bit SR_W-2 carries even parity over the payload below it.
  assign parity_ok = (jdo_q[SR_W-2] == ^jdo_q[SR_W-3:0]);
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    issue_fire   = 1'b0;
    timeout_fire = 1'b0;
    wait_done    = 1'b0;
    case (state)
      IDLE:    if (udr_rise) state_nxt = CAPTURE;
      CAPTURE: state_nxt = ISSUE;
      ISSUE: begin
        issue_fire = parity_ok;
        state_nxt  = parity_ok ? WAIT_ACK : IDLE;
      end
      WAIT_ACK: begin
        // An ack arriving on the timeout cycle still counts as a clean completion.
        if (ack_any) begin
          wait_done = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == ACK_TO_W) begin
          wait_done    = 1'b1;
          timeout_fire = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo_q    <= '0;
      ir_q     <= '0;
      ta_q     <= '0;
      tna_q    <= '0;
      busy_q   <= 1'b0;
      ovr_q    <= '0;
      to_q     <= 1'b0;
      wait_cnt <= '0;
      ack_pend <= 1'b0;
    end else begin
      if (state == IDLE && udr_rise) jdo_q <= bus.sr;
      if (uir_rise) ir_q <= bus.ir_in;
      ta_q  <= (issue_fire &&  jdo_q[SR_W-1]) ? ir_onehot : '0;
      tna_q <= (issue_fire && !jdo_q[SR_W-1]) ? ir_onehot : '0;
      if (issue_fire)     busy_q <= 1'b1;
      else if (wait_done) busy_q <= 1'b0;
      wait_cnt <= (state == WAIT_ACK) ? wait_cnt + 16'd1 : '0;
      // An ack seen while issuing is replayed on the first wait cycle.
      ack_pend <= (state == ISSUE) && bus.cmd_ack;
      if (udr_rise && state != IDLE && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
      if (timeout_fire)  to_q <= 1'b1;
      else if (uir_rise) to_q <= 1'b0;
    end
  end

`ifdef JTAG_CMD_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perr_q <= 1'b0;
    else          perr_q <= (state == ISSUE) && !parity_ok;
  end
  assign bus.parity_err = perr_q;
`endif

  assign bus.jdo            = jdo_q;
  assign bus.take_action    = ta_q;
  assign bus.take_no_action = tna_q;
  assign bus.cmd_busy       = busy_q;
  assign bus.overrun_cnt    = ovr_q;
  assign bus.ack_timeout    = to_q;

  a_one_strobe: assert property (@(posedge clk) disable iff (!reset_n) $onehot0({ta_q, tna_q}));
endmodule

// File: tb/tb_jtag_debug_cmd_sysclk_bridge.sv
// Directed and randomized bench for jtag_debug_cmd_sysclk_bridge with an event-level reference model.
module tb_jtag_debug_cmd_sysclk_bridge;
`ifdef JTAG_CMD_PARITY_EN
  localparam int IR_W = 3;
  localparam int SR_W = 16;
  localparam logic [SR_W-1:0] SR_ACT   = 16'hC001;
  localparam logic [SR_W-1:0] SR_NOACT = 16'h0003;
`else
  localparam int IR_W = 2;
  localparam int SR_W = 38;
  localparam logic [SR_W-1:0] SR_ACT   = 38'h20_0000_0001;
  localparam logic [SR_W-1:0] SR_NOACT = 38'h00_0000_00A5;
`endif
  localparam int SYNC   = 2;
  localparam int ACK_TO = 10;
  localparam int NCMD   = 2 ** IR_W;
  localparam logic [NCMD-1:0] OH0 = 1;
  localparam logic [NCMD-1:0] OH1 = 2;
  localparam logic [NCMD-1:0] OH3 = 8;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  jtag_debug_cmd_sysclk_bridge_if #(.IR_W(IR_W), .SR_W(SR_W)) bus ();

  jtag_debug_cmd_sysclk_bridge #(
    .IR_W(IR_W), .SR_W(SR_W), .SYNC_STAGES(SYNC), .ACK_TO(ACK_TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: sampled input history plus the age of the outstanding command.
  logic [SYNC+1:0] h_udr, h_uir;
  logic            m_active, m_pend, m_busy, m_to, m_perr;
  int              m_age, m_wait;
  logic [SR_W-1:0] m_jdo;
  logic [IR_W-1:0] m_ir;
  logic [NCMD-1:0] m_ta, m_tna;
  logic [7:0]      m_ovr;

  function automatic logic par_ok(input logic [SR_W-1:0] j);
`ifdef JTAG_CMD_PARITY_EN
    return j[SR_W-2] == ^j[SR_W-3:0];
`else
    return j[0] | 1'b1;
`endif
  endfunction

  task automatic model_reset();
    h_udr = '0; h_uir = '0;
    m_active = 0; m_pend = 0; m_busy = 0; m_to = 0; m_perr = 0;
    m_age = 0; m_wait = 0; m_jdo = '0; m_ir = '0; m_ta = '0; m_tna = '0; m_ovr = '0;
  endtask

  task automatic model_step();
    logic ur, irr, was_active, fire;
    if (!reset_n) begin
      model_reset();
      return;
    end
    h_udr = {h_udr[SYNC:0], bus.vs_udr};
    h_uir = {h_uir[SYNC:0], bus.vs_uir};
    ur  = h_udr[SYNC] & ~h_udr[SYNC+1];
    irr = h_uir[SYNC] & ~h_uir[SYNC+1];
    was_active = m_active;
    fire = 0; m_ta = '0; m_tna = '0; m_perr = 0;
    if (m_active) begin
      m_age++;
      if (m_age == 2) begin
        if (par_ok(m_jdo)) begin
          if (m_jdo[SR_W-1]) m_ta[m_ir] = 1'b1;
          else               m_tna[m_ir] = 1'b1;
          m_busy = 1; m_wait = 0; m_pend = bus.cmd_ack;
        end else begin
          m_perr = 1; m_active = 0;
        end
      end else if (m_age > 2) begin
        if (m_pend || bus.cmd_ack) begin
          m_active = 0; m_busy = 0;
        end else if (m_wait == ACK_TO) begin
          m_active = 0; m_busy = 0; fire = 1;
        end else begin
          m_wait++;
        end
      end
    end
    if (ur) begin
      if (was_active) begin
        if (m_ovr != 8'd255) m_ovr++;
      end else begin
        m_active = 1; m_age = 0; m_jdo = bus.sr;
      end
    end
    if (irr) begin
      m_ir = bus.ir_in; m_to = 0;
    end
    if (fire) m_to = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("m_jdo", 64'(bus.jdo), 64'(m_jdo));
      chk("m_take_action", 64'(bus.take_action), 64'(m_ta));
      chk("m_take_no_action", 64'(bus.take_no_action), 64'(m_tna));
      chk("m_cmd_busy", 64'(bus.cmd_busy), 64'(m_busy));
      chk("m_overrun_cnt", 64'(bus.overrun_cnt), 64'(m_ovr));
      chk("m_ack_timeout", 64'(bus.ack_timeout), 64'(m_to));
      chk("m_one_strobe", 64'($countones({bus.take_action, bus.take_no_action}) <= 1), 64'(1));
`ifdef JTAG_CMD_PARITY_EN
      chk("m_parity_err", 64'(bus.parity_err), 64'(m_perr));
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic at_pos(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [SR_W-1:0] rand_sr();
    logic [63:0]     r = {$urandom(), $urandom()};
    logic [SR_W-1:0] s = r[SR_W-1:0];
`ifdef JTAG_CMD_PARITY_EN
    if ($urandom_range(0, 3) != 0) s[SR_W-2] = ^s[SR_W-3:0];
`endif
    return s;
  endfunction

  initial begin
    int udr_hold, uir_hold;
    reset_n = 1'b0;
    bus.ir_in = '0; bus.sr = '0; bus.vs_uir = 1'b0; bus.vs_udr = 1'b0; bus.cmd_ack = 1'b0;
    tick(3);
    chk("rst_jdo", 64'(bus.jdo), 64'(0));
    chk("rst_busy", 64'(bus.cmd_busy), 64'(0));
    chk("rst_strobes", 64'({bus.take_action, bus.take_no_action}), 64'(0));
    reset_n = 1'b1;
    tick(2);

    // Test 1: take_action for ir 1, exactly SYNC+3 cycles after udr rises
    bus.ir_in = 1; bus.vs_uir = 1'b1; tick(4); bus.vs_uir = 1'b0; tick(2);
    bus.sr = SR_ACT; bus.vs_udr = 1'b1;
    at_pos(4);
    chk("t1_early_ta", 64'(bus.take_action), 64'(0));
    at_pos(1);
    chk("t1_ta", 64'(bus.take_action), 64'(OH1));
    chk("t1_jdo", 64'(bus.jdo), 64'(SR_ACT));
    chk("t1_busy", 64'(bus.cmd_busy), 64'(1));
    tick(1); bus.vs_udr = 1'b0;
    tick(2);
    chk("t1_busy_held", 64'(bus.cmd_busy), 64'(1));
    bus.cmd_ack = 1'b1;
    at_pos(1);
    chk("t1_busy_clr", 64'(bus.cmd_busy), 64'(0));
    tick(1); bus.cmd_ack = 1'b0;

    // Test 2: read-only access for ir 3
    tick(2); bus.ir_in = 3; bus.vs_uir = 1'b1; tick(4); bus.vs_uir = 1'b0; tick(2);
    bus.sr = SR_NOACT; bus.vs_udr = 1'b1;
    at_pos(5);
    chk("t2_tna", 64'(bus.take_no_action), 64'(OH3));
    chk("t2_ta", 64'(bus.take_action), 64'(0));
    at_pos(1);
    chk("t2_tna_1cyc", 64'(bus.take_no_action), 64'(0));
    tick(1); bus.vs_udr = 1'b0; bus.cmd_ack = 1'b1; tick(1); bus.cmd_ack = 1'b0;

    // Test 3: three udr rises while a command is outstanding are dropped
    tick(3); bus.sr = SR_ACT; bus.vs_udr = 1'b1;
    tick(1); bus.vs_udr = 1'b0;
    tick(1); bus.vs_udr = 1'b1;
    tick(1); bus.vs_udr = 1'b0; bus.sr = SR_NOACT;
    tick(1); bus.vs_udr = 1'b1; tick(1); bus.vs_udr = 1'b0;
    tick(1); bus.vs_udr = 1'b1; tick(1); bus.vs_udr = 1'b0;
    at_pos(3);
    chk("t3_overrun", 64'(bus.overrun_cnt), 64'(3));
    chk("t3_jdo", 64'(bus.jdo), 64'(SR_ACT));
    chk("t3_busy", 64'(bus.cmd_busy), 64'(1));
    tick(1); bus.cmd_ack = 1'b1; tick(1); bus.cmd_ack = 1'b0;
    for (int i = 0; i < 700; i++) begin
      bus.sr = rand_sr(); bus.vs_udr = 1'b1; tick(1); bus.vs_udr = 1'b0; tick(1);
    end
    tick(20);
    chk("t3_overrun_sat", 64'(bus.overrun_cnt), 64'(255));
    chk("t3_timeout_seen", 64'(bus.ack_timeout), 64'(1));

    // Test 4: uir clears the flag; no ack means timeout ACK_TO+1 cycles after the strobe
    bus.ir_in = 1; bus.vs_uir = 1'b1; tick(4); bus.vs_uir = 1'b0;
    chk("t4_uir_clears", 64'(bus.ack_timeout), 64'(0));
    tick(2); bus.sr = SR_ACT; bus.vs_udr = 1'b1;
    at_pos(5);
    chk("t4_ta", 64'(bus.take_action), 64'(OH1));
    tick(1); bus.vs_udr = 1'b0;
    at_pos(10);
    chk("t4_to_early", 64'(bus.ack_timeout), 64'(0));
    chk("t4_busy_early", 64'(bus.cmd_busy), 64'(1));
    at_pos(1);
    chk("t4_to", 64'(bus.ack_timeout), 64'(1));
    chk("t4_busy_clr", 64'(bus.cmd_busy), 64'(0));
    tick(1); bus.vs_uir = 1'b1;
    at_pos(2);
    chk("t4_to_hold", 64'(bus.ack_timeout), 64'(1));
    at_pos(1);
    chk("t4_to_clr", 64'(bus.ack_timeout), 64'(0));
    tick(1); bus.vs_uir = 1'b0;

    // Test 5: asynchronous reset in the middle of a wait
    tick(2); bus.sr = SR_NOACT; bus.vs_udr = 1'b1; tick(1); bus.vs_udr = 1'b0; tick(8);
    chk("t5_busy_pre", 64'(bus.cmd_busy), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("t5_jdo", 64'(bus.jdo), 64'(0));
    chk("t5_busy", 64'(bus.cmd_busy), 64'(0));
    chk("t5_overrun", 64'(bus.overrun_cnt), 64'(0));
    chk("t5_to", 64'(bus.ack_timeout), 64'(0));
    chk("t5_strobes", 64'({bus.take_action, bus.take_no_action}), 64'(0));
    tick(2); reset_n = 1'b1; tick(2);
    bus.sr = SR_ACT; bus.vs_udr = 1'b1;
    at_pos(5);
    chk("t5_ta_after", 64'(bus.take_action), 64'(OH0));
    tick(1); bus.vs_udr = 1'b0; bus.cmd_ack = 1'b1; tick(1); bus.cmd_ack = 1'b0;

`ifdef JTAG_CMD_PARITY_EN
    // Test 6: parity gate
    tick(3); bus.sr = 16'h8001; bus.vs_udr = 1'b1;
    at_pos(5);
    chk("t6_perr", 64'(bus.parity_err), 64'(1));
    chk("t6_no_strobe", 64'({bus.take_action, bus.take_no_action}), 64'(0));
    chk("t6_busy", 64'(bus.cmd_busy), 64'(0));
    tick(1); bus.vs_udr = 1'b0;
    tick(3); bus.sr = 16'hC001; bus.vs_udr = 1'b1;
    at_pos(5);
    chk("t6_ta", 64'(bus.take_action), 64'(OH0));
    chk("t6_perr_clr", 64'(bus.parity_err), 64'(0));
    tick(1); bus.vs_udr = 1'b0; bus.cmd_ack = 1'b1; tick(1); bus.cmd_ack = 1'b0;
`endif

    // Randomized traffic, occasional resets
    udr_hold = 0; uir_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (udr_hold > 0) udr_hold--;
      else if (bus.vs_udr) bus.vs_udr = 1'b0;
      else if ($urandom_range(0, 5) == 0) begin
        bus.vs_udr = 1'b1; udr_hold = $urandom_range(0, 6); bus.sr = rand_sr();
      end
      if (uir_hold > 0) uir_hold--;
      else if (bus.vs_uir) bus.vs_uir = 1'b0;
      else if ($urandom_range(0, 9) == 0) begin
        bus.vs_uir = 1'b1; uir_hold = $urandom_range(0, 4); bus.ir_in = IR_W'($urandom());
      end
      bus.cmd_ack = ($urandom_range(0, 7) == 0);
      reset_n = ($urandom_range(0, 999) != 0);
    end
    reset_n = 1'b1; bus.cmd_ack = 1'b0;
    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
